// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into OUT_WIDTH-bit words.
// End of frame flushes the residue 1-padded to a byte boundary with a byte-valid mask.
module huffman_bit_packer #(
    parameter int unsigned CODE_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CODE_WIDTH-1:0]         in_code,
    input  logic [$clog2(CODE_WIDTH):0]   in_len,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [OUT_WIDTH/8-1:0]        out_keep,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);
    localparam int unsigned LEN_W   = $clog2(CODE_WIDTH) + 1;
    localparam int unsigned FILL_W  = $clog2(OUT_WIDTH);
    localparam int unsigned SUM_W   = FILL_W + 1;
    localparam int unsigned MERGE_W = OUT_WIDTH + CODE_WIDTH;
    localparam int unsigned SH_W    = $clog2(MERGE_W + 1);
    localparam int unsigned KEEP_W  = OUT_WIDTH / 8;

    typedef enum logic {StRun, StFlush} state_t;

    state_t                state;
    logic [OUT_WIDTH-1:0]  acc;
    logic [FILL_W-1:0]     fill;

    logic [LEN_W-1:0]      len_eff;
    logic [CODE_WIDTH-1:0] code_mask;
    logic [CODE_WIDTH-1:0] code_masked;
    logic [SH_W-1:0]       shamt;
    logic [MERGE_W-1:0]    merge;
    logic [MERGE_W-1:0]    merge_low;
    logic [SUM_W-1:0]      sum;
    logic [FILL_W-1:0]     rem;
    logic                  full;
    logic [SUM_W-1:0]      nbytes;
    logic [SUM_W-1:0]      pad_bits;
    logic [OUT_WIDTH-1:0]  flush_data;
    logic [KEEP_W-1:0]     flush_keep;
    logic                  out_free;

    function automatic logic [OUT_WIDTH-1:0] top_ones(input logic [SUM_W-1:0] n);
        return ~({OUT_WIDTH{1'b1}} >> n);
    endfunction

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == StRun) && out_free;

    always_comb begin
        len_eff     = (in_len > LEN_W'(CODE_WIDTH)) ? LEN_W'(CODE_WIDTH) : in_len;
        code_mask   = {CODE_WIDTH{1'b1}} >> (LEN_W'(CODE_WIDTH) - len_eff);
        code_masked = in_code & code_mask;
        // Shift so the codeword MSB lands `fill` bits below the top of the merge
        shamt       = SH_W'(MERGE_W) - SH_W'(fill) - SH_W'(len_eff);
        merge       = {acc, {CODE_WIDTH{1'b0}}} | (MERGE_W'(code_masked) << shamt);
        merge_low   = merge << OUT_WIDTH;
        sum         = SUM_W'(fill) + SUM_W'(len_eff);
        full        = sum >= SUM_W'(OUT_WIDTH);
        rem         = FILL_W'(sum - SUM_W'(OUT_WIDTH));
        nbytes      = (SUM_W'(fill) + SUM_W'(7)) >> 3;
        pad_bits    = nbytes << 3;
        flush_data  = acc | (top_ones(pad_bits) & ~top_ones(SUM_W'(fill)));
        flush_keep  = ~({KEEP_W{1'b1}} >> nbytes);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StRun;
            acc       <= '0;
            fill      <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                StRun: begin
                    if (in_valid && in_ready) begin
                        if (full) begin
                            out_data  <= merge[MERGE_W-1 -: OUT_WIDTH];
                            out_keep  <= '1;
                            out_last  <= in_last && (rem == '0);
                            out_valid <= 1'b1;
                            acc       <= merge_low[MERGE_W-1 -: OUT_WIDTH];
                            fill      <= rem;
                            if (in_last && (rem != '0)) begin
                                state <= StFlush;
                            end
                        end else begin
                            acc  <= merge[MERGE_W-1 -: OUT_WIDTH];
                            fill <= FILL_W'(sum);
                            if (in_last && (sum != '0)) begin
                                state <= StFlush;
                            end
                        end
                    end
                end
                StFlush: begin
                    if (out_free) begin
                        out_data  <= flush_data;
                        out_keep  <= flush_keep;
                        out_last  <= 1'b1;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        fill      <= '0;
                        state     <= StRun;
                    end
                end
                default: state <= StRun;
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed and randomized checks of huffman_bit_packer against a bit-queue model.
module tb_huffman_bit_packer;
    localparam int CW = 32;
    localparam int OW = 64;
    localparam int KW = OW / 8;
    localparam int LW = $clog2(CW) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] in_code;
    logic [LW-1:0] in_len;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic [KW-1:0] out_keep;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    huffman_bit_packer #(.CODE_WIDTH(CW), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_code   (in_code),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } word_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    bitq[$];
    word_t expq[$];
    bit    accepted;
    bit    rand_ready = 1'b0;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stream model: every accepted codeword appends its bits; full words and flushes pop them.
    task automatic model_accept(input logic [CW-1:0] code, input logic [LW-1:0] len,
                                input bit last);
        int l;
        int n;
        int nb;
        logic [OW-1:0] w;
        logic [KW-1:0] k;
        l = (int'(len) > CW) ? CW : int'(len);
        for (int i = l - 1; i >= 0; i--) bitq.push_back(code[i]);
        if (bitq.size() >= OW) begin
            w = '0;
            for (int i = 0; i < OW; i++) w = {w[OW-2:0], bitq.pop_front()};
            expq.push_back('{w, {KW{1'b1}}, last && (bitq.size() == 0)});
        end
        if (last && bitq.size() > 0) begin
            n  = bitq.size();
            nb = (n + 7) / 8;
            w  = '0;
            k  = '0;
            for (int i = 0; i < OW; i++) begin
                if (i < n) w = {w[OW-2:0], bitq.pop_front()};
                else       w = {w[OW-2:0], (i < nb * 8) ? 1'b1 : 1'b0};
            end
            for (int i = 0; i < nb; i++) k[KW-1-i] = 1'b1;
            expq.push_back('{w, k, 1'b1});
        end
    endtask

    task automatic tick();
        word_t e;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (accepted) model_accept(in_code, in_len, in_last);
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("spurious_word", {{(OW-1){1'b0}}, out_valid}, '0);
            end else begin
                e = expq.pop_front();
                check("word_data", out_data, e.d);
                check("word_keep", OW'(out_keep), OW'(e.k));
                check("word_last", OW'(out_last), OW'(e.l));
            end
        end
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [CW-1:0] code, input logic [LW-1:0] len, input bit last);
        int guard;
        in_code  = code;
        in_len   = len;
        in_last  = last;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            tick();
            guard++;
        end while (!accepted && guard < 200);
        if (!accepted) check("send_timeout", OW'(accepted), OW'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1; in_code = '0; in_len = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", OW'(out_valid), '0);
        check("rst_data", out_data, '0);
        check("rst_keep", OW'(out_keep), '0);
        rst = 1'b0;
        check("rst_in_ready", OW'(in_ready), OW'(1));

        // Eight bytes fill exactly one word
        for (int i = 1; i <= 8; i++) send(CW'(i), LW'(8), 1'b0);
        check("t2_valid", OW'(out_valid), OW'(1));
        check("t2_data", out_data, 64'h0102030405060708);
        check("t2_keep", OW'(out_keep), OW'(8'hFF));
        check("t2_last", OW'(out_last), '0);
        tick();

        // Straddling codeword, then flush of 4 residual bits
        send(32'hAAAAAAAA, LW'(32), 1'b0);
        send(32'h0BBBBBBB, LW'(28), 1'b0);
        send(32'h000000CD, LW'(8), 1'b1);
        check("t3_data", out_data, 64'hAAAAAAAABBBBBBBC);
        check("t3_keep", OW'(out_keep), OW'(8'hFF));
        check("t3_last", OW'(out_last), '0);
        check("t3_in_ready", OW'(in_ready), '0);
        tick();
        check("t3_flush_data", out_data, 64'hDF00000000000000);
        check("t3_flush_keep", OW'(out_keep), OW'(8'h80));
        check("t3_flush_last", OW'(out_last), OW'(1));
        tick();
        check("t3_idle", OW'(out_valid), '0);
        check("t3_ready_back", OW'(in_ready), OW'(1));

        // Backpressure holds the word and blocks input
        out_ready = 1'b0;
        send(32'hFFFFFFFF, LW'(32), 1'b0);
        send(32'hFFFFFFFF, LW'(32), 1'b0);
        in_code = 32'h5; in_len = LW'(3); in_last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_accept", OW'(accepted), '0);
            check("t4_hold_data", out_data, 64'hFFFFFFFFFFFFFFFF);
            check("t4_hold_valid", OW'(out_valid), OW'(1));
            check("t4_in_ready", OW'(in_ready), '0);
        end
        out_ready = 1'b1;
        tick();
        check("t4_same_cycle_accept", OW'(accepted), OW'(1));
        in_valid = 1'b0;
        send(32'h0, LW'(0), 1'b1);
        tick();
        check("t4_flush_data", out_data, 64'hBF00000000000000);
        check("t4_flush_keep", OW'(out_keep), OW'(8'h80));
        tick();

        // Exact word boundary with last: no flush word
        send(32'hFFFFFFFF, LW'(32), 1'b0);
        send(32'hFFFFFFFF, LW'(32), 1'b1);
        check("t5_data", out_data, 64'hFFFFFFFFFFFFFFFF);
        check("t5_keep", OW'(out_keep), OW'(8'hFF));
        check("t5_last", OW'(out_last), OW'(1));
        check("t5_in_ready", OW'(in_ready), OW'(1));
        tick();
        tick();
        check("t5_no_flush", OW'(out_valid), '0);

        // Zero-length last at fill 0, then masking of bits above in_len
        send(32'h0, LW'(0), 1'b1);
        repeat (3) tick();
        check("t6_no_word", OW'(out_valid), '0);
        send(32'hFFFFFFFF, LW'(3), 1'b0);
        send(32'h0, LW'(0), 1'b1);
        tick();
        check("t6_mask_data", out_data, 64'hFF00000000000000);
        check("t6_mask_keep", OW'(out_keep), OW'(8'h80));
        tick();

        // Reset mid-frame with fill 20 and a held output word
        send(32'h12345, LW'(20), 1'b0);
        send(32'hFFFFFFFF, LW'(32), 1'b0);
        out_ready = 1'b0;
        send(32'hCAFEBABE, LW'(32), 1'b0);
        check("t1_pre_valid", OW'(out_valid), OW'(1));
        #2 rst = 1'b1;
        #1;
        check("t1_async_valid", OW'(out_valid), '0);
        check("t1_async_data", out_data, '0);
        check("t1_async_last", OW'(out_last), '0);
        bitq.delete();
        expq.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("t1_in_ready", OW'(in_ready), OW'(1));
        out_ready = 1'b1;
        send(32'h0, LW'(1), 1'b1);
        tick();
        check("t1_fresh_data", out_data, 64'h7F00000000000000);
        check("t1_fresh_keep", OW'(out_keep), OW'(8'h80));
        tick();

        // Randomized frames with random backpressure and idle gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) tick();
            send($urandom, LW'($urandom_range(0, (i % 16 == 0) ? 40 : 32)),
                 (i == 399) || ($urandom_range(0, 9) == 0));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        guard      = 0;
        while ((expq.size() != 0 || out_valid) && guard < 200) begin
            tick();
            guard++;
        end
        check("drain_words", OW'(expq.size()), '0);
        check("drain_bits", OW'(bitq.size()), '0);
        check("drain_idle", OW'(out_valid), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/huffman_bit_packer.md
Name: huffman_bit_packer

Overview:
Packs the variable-length Huffman codewords from the entropy coder into fixed 64-bit words, MSB-first. It sits directly upstream of the coder-to-UART output stage, which writes each word into its 64->8 async FIFO and applies 0xFF/0x00 byte stuffing. No stuffing is done here. At end of frame the block flushes the residual bits, 1-padded to a byte boundary, with a byte-valid mask.

Parameters:
CODE_WIDTH, 32, maximum codeword length in bits (must be <= OUT_WIDTH).
OUT_WIDTH, 64, packed output word width (must be a multiple of 8).

Ports:
clk  input  1  single clock for all logic
rst  input  1  asynchronous, active-high reset
in_code  input  CODE_WIDTH  codeword, right-aligned; bits at or above in_len ignored
in_len  input  $clog2(CODE_WIDTH)+1  codeword length 0..CODE_WIDTH
in_valid  input  1  codeword present
in_last  input  1  last codeword of the frame; triggers flush
in_ready  output  1  codeword accepted when in_valid & in_ready
out_data  output  OUT_WIDTH  packed word; first bit in time at MSB
out_keep  output  OUT_WIDTH/8  byte-valid mask, MSB byte = bit [msb]; 1s are contiguous from MSB
out_last  output  1  final word of the frame
out_valid  output  1  word present
out_ready  input  1  downstream accepts when out_valid & out_ready

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst. While rst=1: out_data=0, out_keep=0, out_last=0, out_valid=0, accumulator=0, fill=0, state=RUN. Reset asserted mid-frame discards all pending bits and any held output word.
- State: accumulator acc[OUT_WIDTH-1:0] holds fill bits, left-aligned. Fill counter runs 0..OUT_WIDTH-1.
- FSM has two states, RUN and FLUSH.
- in_ready = (state==RUN) & (!out_valid | out_ready). It is combinational and does not depend on in_valid.
- Output register semantics: valid/ready. While out_valid=1 & out_ready=0, out_data, out_keep and out_last are held stable. out_valid drops the cycle after a handshake unless a new word is loaded in the same cycle.
- Accept in RUN. Let L = min(in_len, CODE_WIDTH). Masked code = in_code & ((1<<L)-1). The code is placed so its MSB lands at bit position fill from the top of an (OUT_WIDTH+CODE_WIDTH)-bit merge. Then f' = fill+L.
- Case f' >= OUT_WIDTH:
  - Next edge: out_data = top OUT_WIDTH bits of the merge, out_keep = all 1s, out_valid = 1.
  - acc = remaining bits, left-aligned; fill = f' - OUT_WIDTH.
  - out_last = in_last & (fill_new == 0).
  - If in_last & fill_new > 0, go to FLUSH.
- Case f' < OUT_WIDTH:
  - acc = merge top, fill = f'. No word is emitted unless flushing.
  - If in_last & f' > 0, go to FLUSH.
  - If in_last & f' == 0, nothing is emitted and the state stays RUN.
- Latency: a full word appears one cycle after the accepting edge.
- FLUSH, when !out_valid | out_ready:
  - out_data = acc with bits from position fill down to the next byte boundary set to 1; lower bytes are 0.
  - out_keep = ceil(fill/8) leading 1s. Example: fill=13 gives keep 8'b1100_0000.
  - out_last = 1, out_valid = 1.
  - acc = 0, fill = 0, state = RUN.
  - in_ready = 0 throughout FLUSH.
- L=0 with in_valid is accepted as a no-op on the bits; in_last on it still flushes.
- Simultaneous output handshake and new load in the same cycle is allowed; the new word overwrites the register with no bubble.

Test Plan:
1. Assert rst for 3 cycles mid-frame with fill=20 and out_valid=1 -> all outputs 0 immediately; in_ready=1 on the first cycle after release; next frame packs from bit 63.
2. Eight codes, L=8, values 0x01..0x08, out_ready=1 -> exactly one word 0x0102030405060708, keep=0xFF, last=0, one cycle after the 8th accept.
3. Straddle: 0xAAAAAAAA/L32, 0x0BBBBBBB/L28, 0xCD/L8 with in_last -> word 0xAAAAAAAABBBBBBBC keep 0xFF last=0, then flush word 0xDF00000000000000 keep 0x80 last=1; in_ready=0 between the two words.
4. Backpressure: hold out_ready=0 while a word is valid -> out_data/keep/last stable, in_ready=0, no input accepted. Raise out_ready with in_valid=1 -> handshake and new accept in the same cycle, no lost bits.
5. Exact boundary: two 0xFFFFFFFF/L32, the second with in_last -> one word 0xFFFFFFFFFFFFFFFF keep 0xFF last=1, no flush word, state RUN.
6. in_len=0 with in_last at fill=0 -> no output word. in_code=0xFFFFFFFF with in_len=3 -> only 3 ones enter the stream.
